pusch_crc_attach: RTL and testbench
===================================

Name: pusch_crc_attach

Overview:
- Sits directly upstream of the serial CRC-16 generator in the PUSCH transmit chain.
- Accepts transport-block (TB) bytes on a valid/ready handshake and serialises them MSB-first into one contiguous bit stream, feeding the CRC stage (DATA/ACTIVE) and the downstream bit output simultaneously.
- After the last payload bit, waits for the CRC stage's 16-bit result and appends it, so downstream receives TB bits followed by 16 parity bits.

Parameters:
- LEN_W, 12, width of the TB length input in bytes.
- CRC_TIMEOUT, 32, maximum cycles to wait for crc_valid after the last payload bit.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle TB start request.
- tb_len  in  LEN_W  TB length in bytes; sampled on the accepted start.
- in_data  in  8  payload byte.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid && in_ready (combinational).
- crc_data  out  1  serial bit to the CRC stage's DATA input.
- crc_active  out  1  to the CRC stage's ACTIVE input; high for every payload bit, contiguous.
- crc_word  in  16  CRC stage's data_out.
- crc_valid  in  1  CRC stage's Valid.
- out_bit  out  1  serial output bit.
- out_valid  out  1  out_bit valid; no backpressure.
- out_last  out  1  high with the final parity bit.
- busy  out  1  high in any state other than IDLE.
- err  out  1  one-cycle error pulse.

Behaviour:
- Reset values: all registered outputs 0, state IDLE, counters 0, parity register 0. in_ready is 0 in reset.
- crc_data, crc_active, out_bit, out_valid and out_last are registered.
- IDLE:
  - start with tb_len != 0 latches the length into byte_cnt and moves to LOAD.
  - start with tb_len == 0 is ignored; no err.
- LOAD:
  - in_ready = 1.
  - On handshake, load the byte into an 8-bit shift register, set bit_cnt = 0, go to PAYLOAD.
  - Waiting here is legal: no bits have been emitted yet.
- PAYLOAD, one bit per cycle:
  - out_bit = crc_data = sr[7], out_valid = crc_active = 1, then shift left.
  - The first bit appears on the cycle after the LOAD handshake.
  - On bit_cnt == 7 of a non-final byte, in_ready = 1. On handshake, the next byte loads and the stream continues with no gap.
  - Underrun (no handshake at that boundary): err pulses, crc_active falls, go to DRAIN.
  - On bit 7 of the final byte, go to WAIT_CRC. crc_active is low from the next cycle.
- WAIT_CRC:
  - out_valid = 0, crc_active = 0.
  - On the first cycle crc_valid = 1, latch crc_word into the parity register and go to APPEND.
  - If CRC_TIMEOUT cycles elapse without crc_valid: err, go to IDLE, no parity emitted.
- APPEND:
  - 16 cycles; out_valid = 1, out_bit = par[k] for k = 0..15 (crc_word[0] first), crc_active = 0.
  - out_last = 1 on k = 15, then go to IDLE.
- DRAIN:
  - Wait for crc_valid or CRC_TIMEOUT, discarding the result, then go to IDLE.
  - This guarantees the CRC stage is quiescent before the next TB.
- start is ignored in any state except IDLE.
- Totals: TB of N bytes gives exactly 8N + 16 out_valid cycles.
  - Payload bits are contiguous.
  - The gap between the last payload bit and the first parity bit equals the crc_valid latency plus 1.
- Reset mid-operation: immediate return to reset values. The CRC stage shares RST, so both restart cleanly.

Optional Feature:
- Macro PUSCH_CRC_ATTACH_STATS_EN.
- When defined: adds outputs tb_count[15:0] and err_count[15:0], both reset to 0.
  - tb_count increments on each out_last.
  - err_count increments on each err pulse.
  - Both wrap at 0xFFFF -> 0.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- tb_len = 1, in_data = 0xA5; CRC stub raises crc_valid 18 cycles after crc_active falls with crc_word = 0xC35A.
  - Expect out_bit 1,0,1,0,0,1,0,1 on 8 contiguous cycles with crc_active high.
  - Then parity bits 0,1,0,1,1,0,1,0,1,1,0,0,0,0,1,1 (LSB first); out_last on the 24th valid bit; busy falls the next cycle.
- tb_len = 3, bytes 0x01, 0xFF, 0x80 offered with in_valid held high.
  - Expect 24 gap-free payload bits; in_ready high only in LOAD and on bit 7 of bytes 1 and 2.
  - Expect 40 total out_valid cycles.
- tb_len = 2, second byte withheld at the boundary.
  - Expect err pulse after 8 bits, crc_active low, no parity output.
  - After the stub crc_valid, expect return to IDLE.
- CRC stub never asserts crc_valid.
  - Expect err exactly CRC_TIMEOUT = 32 cycles after entering WAIT_CRC, then IDLE, no parity bits.
- RST asserted during APPEND at parity bit 5.
  - Expect all outputs 0 immediately, busy = 0.
  - A following start with tb_len = 1 completes normally.
- start with tb_len = 0, and start while busy.
  - Both ignored: no err, no change in the output stream.
  - With PUSCH_CRC_ATTACH_STATS_EN, tb_count and err_count track the counts from the scenarios above.

Source files
------------

// File: rtl/pusch_crc_attach.sv
// rtl/pusch_crc_attach.sv - PUSCH TB byte serialiser with CRC-16 parity append
// Optional build macro: PUSCH_CRC_ATTACH_STATS_EN adds tb_count/err_count outputs.
module pusch_crc_attach #(
   parameter int LEN_W       = 12,
   parameter int CRC_TIMEOUT = 32
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   input  logic [LEN_W-1:0] tb_len,
   input  logic [7:0]       in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             crc_data,
   output logic             crc_active,
   input  logic [15:0]      crc_word,
   input  logic             crc_valid,
   output logic             out_bit,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy,
   output logic             err
`ifdef PUSCH_CRC_ATTACH_STATS_EN
   ,
   output logic [15:0]      tb_count,
   output logic [15:0]      err_count
`endif
);
   localparam int TMO_W = $clog2(CRC_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_PAYLOAD, S_WAIT_CRC, S_APPEND, S_DRAIN
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [LEN_W-1:0] r_byte_cnt, w_byte_cnt_nxt;
   logic [7:0]       r_sr, w_sr_nxt;
   logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
   logic [15:0]      r_par, w_par_nxt;
   logic [3:0]       r_k, w_k_nxt;
   logic [TMO_W-1:0] r_tmo, w_tmo_nxt;
   logic             r_crc_data, w_crc_data_nxt;
   logic             r_crc_active, w_crc_active_nxt;
   logic             r_out_bit, w_out_bit_nxt;
   logic             r_out_valid, w_out_valid_nxt;
   logic             r_out_last, w_out_last_nxt;
   logic             r_err, w_err_nxt;

   logic             w_final;
   logic             w_hs;
   logic             w_tmo_hit;
   logic [3:0]       w_kp1;

   assign w_final   = (r_byte_cnt == LEN_W'(1));
   assign w_tmo_hit = (r_tmo == TMO_W'(CRC_TIMEOUT - 1));
   assign w_kp1     = r_k + 4'd1;
   assign in_ready  = (r_state == S_LOAD) ||
                      ((r_state == S_PAYLOAD) && (r_bit_cnt == 3'd7) && !w_final);
   assign w_hs      = in_valid && in_ready;
   assign busy      = (r_state != S_IDLE);

   assign crc_data   = r_crc_data;
   assign crc_active = r_crc_active;
   assign out_bit    = r_out_bit;
   assign out_valid  = r_out_valid;
   assign out_last   = r_out_last;
   assign err        = r_err;

   // State and datapath registers; a loaded byte's MSB goes out on the handshake edge
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_state      <= S_IDLE;
         r_byte_cnt   <= '0;
         r_sr         <= '0;
         r_bit_cnt    <= '0;
         r_par        <= '0;
         r_k          <= '0;
         r_tmo        <= '0;
         r_crc_data   <= 1'b0;
         r_crc_active <= 1'b0;
         r_out_bit    <= 1'b0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_err        <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_byte_cnt   <= w_byte_cnt_nxt;
         r_sr         <= w_sr_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_par        <= w_par_nxt;
         r_k          <= w_k_nxt;
         r_tmo        <= w_tmo_nxt;
         r_crc_data   <= w_crc_data_nxt;
         r_crc_active <= w_crc_active_nxt;
         r_out_bit    <= w_out_bit_nxt;
         r_out_valid  <= w_out_valid_nxt;
         r_out_last   <= w_out_last_nxt;
         r_err        <= w_err_nxt;
      end
   end

   // Next-state and next-output logic; outputs default to idle-low every cycle
   always_comb begin
      w_state_nxt      = r_state;
      w_byte_cnt_nxt   = r_byte_cnt;
      w_sr_nxt         = r_sr;
      w_bit_cnt_nxt    = r_bit_cnt;
      w_par_nxt        = r_par;
      w_k_nxt          = r_k;
      w_tmo_nxt        = r_tmo;
      w_crc_data_nxt   = 1'b0;
      w_crc_active_nxt = 1'b0;
      w_out_bit_nxt    = 1'b0;
      w_out_valid_nxt  = 1'b0;
      w_out_last_nxt   = 1'b0;
      w_err_nxt        = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && (tb_len != '0)) begin
               w_byte_cnt_nxt = tb_len;
               w_state_nxt    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (w_hs) begin
               w_out_bit_nxt    = in_data[7];
               w_crc_data_nxt   = in_data[7];
               w_out_valid_nxt  = 1'b1;
               w_crc_active_nxt = 1'b1;
               w_sr_nxt         = {in_data[6:0], 1'b0};
               w_bit_cnt_nxt    = 3'd0;
               w_state_nxt      = S_PAYLOAD;
            end
         end
         S_PAYLOAD: begin
            // r_bit_cnt is the index of the bit currently on the outputs
            if (r_bit_cnt != 3'd7) begin
               w_out_bit_nxt    = r_sr[7];
               w_crc_data_nxt   = r_sr[7];
               w_out_valid_nxt  = 1'b1;
               w_crc_active_nxt = 1'b1;
               w_sr_nxt         = {r_sr[6:0], 1'b0};
               w_bit_cnt_nxt    = r_bit_cnt + 3'd1;
            end else if (w_final) begin
               w_tmo_nxt   = '0;
               w_state_nxt = S_WAIT_CRC;
            end else if (w_hs) begin
               w_out_bit_nxt    = in_data[7];
               w_crc_data_nxt   = in_data[7];
               w_out_valid_nxt  = 1'b1;
               w_crc_active_nxt = 1'b1;
               w_sr_nxt         = {in_data[6:0], 1'b0};
               w_bit_cnt_nxt    = 3'd0;
               w_byte_cnt_nxt   = r_byte_cnt - LEN_W'(1);
            end else begin
               w_err_nxt   = 1'b1;
               w_tmo_nxt   = '0;
               w_state_nxt = S_DRAIN;
            end
         end
         S_WAIT_CRC: begin
            if (crc_valid) begin
               w_par_nxt       = crc_word;
               w_out_bit_nxt   = crc_word[0];
               w_out_valid_nxt = 1'b1;
               w_k_nxt         = 4'd0;
               w_state_nxt     = S_APPEND;
            end else if (w_tmo_hit) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + TMO_W'(1);
            end
         end
         S_APPEND: begin
            // r_k is the parity index currently on the outputs
            if (r_k == 4'd15) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_out_bit_nxt   = r_par[w_kp1];
               w_out_valid_nxt = 1'b1;
               w_out_last_nxt  = (r_k == 4'd14);
               w_k_nxt         = w_kp1;
            end
         end
         S_DRAIN: begin
            if (crc_valid || w_tmo_hit) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_tmo_nxt = r_tmo + TMO_W'(1);
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

`ifdef PUSCH_CRC_ATTACH_STATS_EN
   logic [15:0] r_tb_count;
   logic [15:0] r_err_count;

   // Completed-TB and error-pulse counters, wrapping at 16 bits
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_tb_count  <= '0;
         r_err_count <= '0;
      end else begin
         if (r_out_last) r_tb_count  <= r_tb_count + 16'd1;
         if (r_err)      r_err_count <= r_err_count + 16'd1;
      end
   end

   assign tb_count  = r_tb_count;
   assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_pusch_crc_attach.sv
// tb/tb_pusch_crc_attach.sv - directed self-checking bench for pusch_crc_attach
module tb_pusch_crc_attach;
   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        start = 1'b0;
   logic [11:0] tb_len = '0;
   logic [7:0]  in_data = '0;
   logic        in_valid = 1'b0;
   logic [15:0] crc_word = '0;
   logic        crc_valid = 1'b0;
   logic        in_ready, crc_data, crc_active, out_bit, out_valid, out_last, busy, err;
`ifdef PUSCH_CRC_ATTACH_STATS_EN
   logic [15:0] tb_count, err_count;
`endif

   int          n_assert = 0;
   int          n_fail = 0;
   int          cyc = 0;
   int          stub_lat = -1;
   logic [15:0] stub_word = '0;
   int          fall_cnt = -1;
   logic        prev_act = 1'b0;
   logic [7:0]  bytes[$];
   int          vcyc[$];
   int          rcyc[$];
   logic [63:0] rx;
   int          nact, nlast, last_idx, nerr, err_cyc, busy0_cyc, ld_cyc;
   logic        act_at_err;
   bit          to;

   always #5 CLK = ~CLK;

   pusch_crc_attach dut (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start),
      .tb_len     (tb_len),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .crc_data   (crc_data),
      .crc_active (crc_active),
      .crc_word   (crc_word),
      .crc_valid  (crc_valid),
      .out_bit    (out_bit),
      .out_valid  (out_valid),
      .out_last   (out_last),
      .busy       (busy),
      .err        (err)
`ifdef PUSCH_CRC_ATTACH_STATS_EN
      ,
      .tb_count   (tb_count),
      .err_count  (err_count)
`endif
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_logs();
      vcyc.delete();
      rcyc.delete();
      rx = '0;
      nact = 0; nlast = 0; last_idx = 0; nerr = 0;
      err_cyc = -1; busy0_cyc = -1;
      act_at_err = 1'b0;
      fall_cnt = -1;
      prev_act = 1'b0;
   endtask

   // one clock: feed bytes, log outputs, run the CRC-stage stub
   task automatic cycle();
      logic hs;
      hs = in_valid && in_ready;
      @(posedge CLK);
      #1;
      cyc++;
      if (hs) void'(bytes.pop_front());
      in_valid = (bytes.size() > 0);
      in_data  = (bytes.size() > 0) ? bytes[0] : 8'h00;
      if (out_valid) begin
         vcyc.push_back(cyc);
         rx = {rx[62:0], out_bit};
         if (crc_active) nact++;
         if (out_last) begin
            nlast++;
            last_idx = vcyc.size();
         end
      end
      if (in_ready) rcyc.push_back(cyc);
      if (err) begin
         nerr++;
         err_cyc = cyc;
         act_at_err = crc_active;
      end
      if (prev_act && !crc_active) fall_cnt = 0;
      else if (fall_cnt >= 0) fall_cnt++;
      prev_act  = crc_active;
      crc_valid = (stub_lat >= 0) && (fall_cnt == stub_lat);
      crc_word  = stub_word;
   endtask

   task automatic run_until_idle(input int budget, output bit timed_out);
      timed_out = 1'b1;
      for (int i = 0; i < budget; i++) begin
         cycle();
         if (!busy) begin
            busy0_cyc = cyc;
            timed_out = 1'b0;
            return;
         end
      end
   endtask

   task automatic kick(input logic [11:0] len);
      tb_len = len;
      start  = 1'b1;
      cycle();
      start  = 1'b0;
      ld_cyc = cyc;
   endtask

   initial begin
      // reset state
      #12;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_outs", {crc_data, crc_active, out_bit, out_last, err}, 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;

      // 1: single byte 0xA5, CRC latency 18, word 0xC35A
      clear_logs();
      stub_lat = 18; stub_word = 16'hC35A;
      bytes.push_back(8'hA5);
      kick(12'd1);
      check("t1_busy", busy, 1);
      run_until_idle(200, to);
      check("t1_timeout", to, 0);
      check("t1_nvalid", vcyc.size(), 24);
      check("t1_bits", rx[23:0], 24'hA55AC3);
      check("t1_first", vcyc[0] - ld_cyc, 1);
      check("t1_nact", nact, 8);
      check("t1_contig", vcyc[7] - vcyc[0], 7);
      check("t1_gap", vcyc[8] - vcyc[7], 20);
      check("t1_nlast", nlast, 1);
      check("t1_last_idx", last_idx, 24);
      check("t1_busyfall", busy0_cyc - vcyc[23], 1);
      check("t1_err", nerr, 0);

      // 2: three bytes with in_valid held high
      clear_logs();
      bytes.push_back(8'h01); bytes.push_back(8'hFF); bytes.push_back(8'h80);
      kick(12'd3);
      run_until_idle(300, to);
      check("t2_timeout", to, 0);
      check("t2_nvalid", vcyc.size(), 40);
      check("t2_bits", rx[39:0], 40'h01FF805AC3);
      check("t2_contig", vcyc[23] - vcyc[0], 23);
      check("t2_nact", nact, 24);
      check("t2_nready", rcyc.size(), 3);
      check("t2_ready0", rcyc[0], ld_cyc);
      check("t2_ready1", rcyc[1], vcyc[7]);
      check("t2_ready2", rcyc[2], vcyc[15]);
      check("t2_err", nerr, 0);

      // 3: second byte withheld -> underrun, drain on stub crc_valid
      clear_logs();
      bytes.push_back(8'h3C);
      kick(12'd2);
      run_until_idle(200, to);
      check("t3_timeout", to, 0);
      check("t3_nvalid", vcyc.size(), 8);
      check("t3_bits", rx[7:0], 8'h3C);
      check("t3_nerr", nerr, 1);
      check("t3_err_pos", err_cyc - vcyc[7], 1);
      check("t3_act_at_err", act_at_err, 0);
      check("t3_idle_pos", busy0_cyc - err_cyc, 19);

      // 4: CRC stage never answers -> timeout error
      clear_logs();
      stub_lat = -1;
      bytes.push_back(8'h00);
      kick(12'd1);
      run_until_idle(200, to);
      check("t4_timeout", to, 0);
      check("t4_nvalid", vcyc.size(), 8);
      check("t4_nerr", nerr, 1);
      check("t4_err_pos", err_cyc - vcyc[7], 33);
      check("t4_idle_pos", busy0_cyc, err_cyc);

      // 5: reset during parity bit 5, then a clean TB
      clear_logs();
      stub_lat = 18; stub_word = 16'hC35A;
      bytes.push_back(8'hA5);
      kick(12'd1);
      for (int i = 0; i < 200; i++) begin
         if (vcyc.size() == 14) break;
         cycle();
      end
      check("t5_reached", vcyc.size(), 14);
`ifdef PUSCH_CRC_ATTACH_STATS_EN
      check("t5_tb_count", tb_count, 2);
      check("t5_err_count", err_count, 2);
`endif
      #2;
      RST = 1'b0;
      #1;
      check("t5_rst_outs", {out_valid, out_bit, out_last, crc_active, crc_data, err}, 0);
      check("t5_rst_busy", busy, 0);
      check("t5_rst_ready", in_ready, 0);
      @(posedge CLK);
      #1;
      RST = 1'b1;
      clear_logs();
      bytes.delete();
      repeat (3) cycle();
      check("t5_quiet", vcyc.size(), 0);
      clear_logs();
      stub_lat = 3; stub_word = 16'h1234;
      bytes.push_back(8'h5A);
      kick(12'd1);
      run_until_idle(200, to);
      check("t5b_timeout", to, 0);
      check("t5b_nvalid", vcyc.size(), 24);
      check("t5b_bits", rx[23:0], 24'h5A2C48);
      check("t5b_err", nerr, 0);

      // 6: zero-length start ignored; start while busy ignored
      clear_logs();
      kick(12'd0);
      repeat (4) cycle();
      check("t6_len0_busy", busy, 0);
      check("t6_len0_valid", vcyc.size(), 0);
      check("t6_len0_err", nerr, 0);
      clear_logs();
      stub_lat = 2; stub_word = 16'hFFFF;
      bytes.push_back(8'hC3);
      kick(12'd1);
      for (int i = 0; i < 50; i++) begin
         if (vcyc.size() == 3) break;
         cycle();
      end
      kick(12'd2);
      run_until_idle(200, to);
      check("t6_timeout", to, 0);
      check("t6_nvalid", vcyc.size(), 24);
      check("t6_bits", rx[23:0], 24'hC3FFFF);
      check("t6_err", nerr, 0);
      repeat (4) cycle();
      check("t6_stay_idle", busy, 0);
      check("t6_no_extra", vcyc.size(), 24);
`ifdef PUSCH_CRC_ATTACH_STATS_EN
      check("t6_tb_count", tb_count, 2);
      check("t6_err_count", err_count, 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
